// File: rtl/flow_lookup_engine_if.sv
// Key/result handshake bundle between the flow-key generator, the lookup engine and the result consumer.
interface flow_lookup_engine_if #(
  parameter int KEY_WIDTH = 128,
  parameter int ID_WIDTH  = 6
);
  logic                 key_valid;
  logic [KEY_WIDTH-1:0] key;
  logic                 key_ready;
  logic                 result_valid;
  logic                 result_ready;
  logic                 result_hit;
  logic                 result_new;
  logic                 result_full;
  logic [ID_WIDTH-1:0]  result_id;

  // master: key source and result sink; slave: the lookup engine
  modport master (
    output key_valid, key, result_ready,
    input  key_ready, result_valid, result_hit, result_new, result_full, result_id
  );
  modport slave (
    input  key_valid, key, result_ready,
    output key_ready, result_valid, result_hit, result_new, result_full, result_id
  );
endinterface

// File: rtl/flow_lookup_engine.sv
// Hashed flow table with linear probing, insert-on-miss, occupancy/drop stats and a swept clear.
// Optional per-flow packet counters and stats read port: define FLOW_STATS_EN.
module flow_lookup_engine #(
  parameter int KEY_WIDTH = 128,
  parameter int DEPTH     = 64,
  parameter int PROBE     = 4,
  parameter int CNT_WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  flow_lookup_engine_if.slave      bus,
  input  logic                     clear_req,
  output logic                     clear_busy,
  output logic [$clog2(DEPTH):0]   occupancy,
  output logic [CNT_WIDTH-1:0]     drop_cnt,
  input  logic                     stat_re,
  input  logic [$clog2(DEPTH)-1:0] stat_addr,
  output logic [CNT_WIDTH-1:0]     stat_rdata,
  output logic                     stat_rvalid
);
  localparam int W      = $clog2(DEPTH);
  localparam int NSLICE = (KEY_WIDTH + W - 1) / W;
  localparam int PAD_W  = NSLICE * W;
  localparam logic [W-1:0] LAST_PROBE = W'(PROBE - 1);
  localparam logic [W-1:0] LAST_INDEX = W'(DEPTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_PROBE, S_RESULT, S_CLEAR} state_t;

  state_t               state_reg;
  logic [KEY_WIDTH-1:0] key_reg;
  logic [W-1:0]         hash_reg;
  logic [W-1:0]         probe_reg;
  logic [W-1:0]         clr_idx_reg;
  logic                 clear_pend_reg;
  logic [DEPTH-1:0]     valid_reg;
  logic [KEY_WIDTH-1:0] key_mem [DEPTH];
  logic [W:0]           occ_reg;
  logic [CNT_WIDTH-1:0] drop_reg;
  logic                 res_valid_reg;
  logic                 res_hit_reg;
  logic                 res_new_reg;
  logic                 res_full_reg;
  logic [W-1:0]         res_id_reg;
  logic                 stat_rvalid_reg;
  logic [CNT_WIDTH-1:0] stat_rdata_reg;

  logic [PAD_W-1:0]     key_pad;
  logic [W-1:0]         key_hash;
  logic [W-1:0]         slot;
  logic                 key_fire;
  logic                 probe_hit;
  logic                 probe_ins;
  logic                 probe_full;

  // Fold the zero-padded key into W-bit slices
  assign key_pad = PAD_W'(bus.key);
  always_comb begin
    key_hash = '0;
    for (int s = 0; s < NSLICE; s++) begin
      key_hash = key_hash ^ key_pad[s*W +: W];
    end
  end

  // W-bit add wraps naturally at DEPTH
  assign slot       = hash_reg + probe_reg;
  assign probe_hit  = (state_reg == S_PROBE) && valid_reg[slot] && (key_mem[slot] == key_reg);
  assign probe_ins  = (state_reg == S_PROBE) && !valid_reg[slot];
  assign probe_full = (state_reg == S_PROBE) && valid_reg[slot] && (key_mem[slot] != key_reg) &&
                      (probe_reg == LAST_PROBE);

  assign bus.key_ready = (state_reg == S_IDLE) && !clear_pend_reg && !clear_req;
  assign key_fire      = bus.key_valid && bus.key_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= S_IDLE;
      key_reg        <= '0;
      hash_reg       <= '0;
      probe_reg      <= '0;
      clr_idx_reg    <= '0;
      clear_pend_reg <= 1'b0;
      valid_reg      <= '0;
      occ_reg        <= '0;
      drop_reg       <= '0;
      res_valid_reg  <= 1'b0;
      res_hit_reg    <= 1'b0;
      res_new_reg    <= 1'b0;
      res_full_reg   <= 1'b0;
      res_id_reg     <= '0;
    end else begin
      if (clear_req && state_reg != S_CLEAR) begin
        clear_pend_reg <= 1'b1;
      end
      case (state_reg)
        S_IDLE: begin
          if (clear_pend_reg) begin
            clear_pend_reg <= 1'b0;
            clr_idx_reg    <= '0;
            state_reg      <= S_CLEAR;
          end else if (key_fire) begin
            key_reg   <= bus.key;
            hash_reg  <= key_hash;
            probe_reg <= '0;
            state_reg <= S_PROBE;
          end
        end
        S_PROBE: begin
          if (probe_hit) begin
            res_valid_reg <= 1'b1;
            res_hit_reg   <= 1'b1;
            res_id_reg    <= slot;
            state_reg     <= S_RESULT;
          end else if (probe_ins) begin
            valid_reg[slot] <= 1'b1;
            occ_reg         <= occ_reg + 1'b1;
            res_valid_reg   <= 1'b1;
            res_new_reg     <= 1'b1;
            res_id_reg      <= slot;
            state_reg       <= S_RESULT;
          end else if (probe_full) begin
            if (drop_reg != '1) begin
              drop_reg <= drop_reg + 1'b1;
            end
            res_valid_reg <= 1'b1;
            res_full_reg  <= 1'b1;
            res_id_reg    <= '0;
            state_reg     <= S_RESULT;
          end else begin
            probe_reg <= probe_reg + 1'b1;
          end
        end
        S_RESULT: begin
          if (bus.result_ready) begin
            res_valid_reg <= 1'b0;
            res_hit_reg   <= 1'b0;
            res_new_reg   <= 1'b0;
            res_full_reg  <= 1'b0;
            res_id_reg    <= '0;
            state_reg     <= S_IDLE;
          end
        end
        S_CLEAR: begin
          valid_reg[clr_idx_reg] <= 1'b0;
          clr_idx_reg            <= clr_idx_reg + 1'b1;
          if (clr_idx_reg == LAST_INDEX) begin
            occ_reg   <= '0;
            state_reg <= S_IDLE;
          end
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

  // Stored keys need no reset: a slot is only trusted while its valid bit is set
  always_ff @(posedge clk) begin
    if (probe_ins) begin
      key_mem[slot] <= key_reg;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_rvalid_reg <= 1'b0;
    end else begin
      stat_rvalid_reg <= stat_re;
    end
  end

`ifdef FLOW_STATS_EN
  logic [CNT_WIDTH-1:0] cnt_mem [DEPTH];

  // Read samples the pre-update value when a lookup touches the same slot
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int d = 0; d < DEPTH; d++) begin
        cnt_mem[d] <= '0;
      end
      stat_rdata_reg <= '0;
    end else begin
      if (stat_re) begin
        stat_rdata_reg <= cnt_mem[stat_addr];
      end
      if (state_reg == S_CLEAR) begin
        cnt_mem[clr_idx_reg] <= '0;
      end else if (probe_hit) begin
        if (cnt_mem[slot] != '1) begin
          cnt_mem[slot] <= cnt_mem[slot] + 1'b1;
        end
      end else if (probe_ins) begin
        cnt_mem[slot] <= CNT_WIDTH'(1);
      end
    end
  end
`else
  logic stat_addr_unused;
  assign stat_addr_unused = ^stat_addr;
  assign stat_rdata_reg   = '0;
`endif

  assign bus.result_valid = res_valid_reg;
  assign bus.result_hit   = res_hit_reg;
  assign bus.result_new   = res_new_reg;
  assign bus.result_full  = res_full_reg;
  assign bus.result_id    = res_id_reg;
  assign clear_busy       = clear_pend_reg || (state_reg == S_CLEAR);
  assign occupancy        = occ_reg;
  assign drop_cnt         = drop_reg;
  assign stat_rdata       = stat_rdata_reg;
  assign stat_rvalid      = stat_rvalid_reg;
endmodule

// File: tb/tb_flow_lookup_engine.sv
// Directed bench for flow_lookup_engine (DEPTH=8, PROBE=4, 16-bit keys) against a table-level model.
module tb_flow_lookup_engine;
  localparam int KW    = 16;
  localparam int DEPTH = 8;
  localparam int PROBE = 4;
  localparam int CW    = 32;
  localparam int IW    = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          clear_req;
  logic          clear_busy;
  logic [IW:0]   occupancy;
  logic [CW-1:0] drop_cnt;
  logic          stat_re;
  logic [IW-1:0] stat_addr;
  logic [CW-1:0] stat_rdata;
  logic          stat_rvalid;

  int n_checks = 0;
  int n_errors = 0;

  flow_lookup_engine_if #(.KEY_WIDTH(KW), .ID_WIDTH(IW)) bus ();

  flow_lookup_engine #(
    .KEY_WIDTH(KW), .DEPTH(DEPTH), .PROBE(PROBE), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .clear_req(clear_req), .clear_busy(clear_busy),
    .occupancy(occupancy), .drop_cnt(drop_cnt),
    .stat_re(stat_re), .stat_addr(stat_addr),
    .stat_rdata(stat_rdata), .stat_rvalid(stat_rvalid)
  );

  always #5 clk = ~clk;

  // Table model: slot contents, counters and the expected result of the lookup in flight
  bit            m_valid [DEPTH];
  logic [KW-1:0] m_key   [DEPTH];
  int            m_cnt   [DEPTH];
  int            m_occ;
  int            m_drop;
  bit            exp_on;
  bit            exp_hit, exp_new, exp_full;
  int            exp_id, exp_lat;

  logic [KW-1:0] k7  [5] = '{16'h0007, 16'h0038, 16'h01C0, 16'h0E00, 16'h7000};
  int            id7 [4] = '{7, 0, 1, 2};

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  // Bit b of the key toggles hash bit (b mod 3)
  function automatic int model_hash(input logic [KW-1:0] k);
    int h = 0;
    for (int b = 0; b < KW; b++) begin
      if (k[b]) h = h ^ (1 << (b % IW));
    end
    return h;
  endfunction

  function automatic void model_reset();
    for (int d = 0; d < DEPTH; d++) begin
      m_valid[d] = 1'b0;
      m_key[d]   = '0;
      m_cnt[d]   = 0;
    end
    m_occ  = 0;
    m_drop = 0;
    exp_on = 1'b0;
  endfunction

  function automatic void model_lookup(input logic [KW-1:0] k);
    int h = model_hash(k);
    exp_hit  = 1'b0;
    exp_new  = 1'b0;
    exp_full = 1'b1;
    exp_id   = 0;
    exp_lat  = 1 + PROBE;
    for (int i = 0; i < PROBE; i++) begin
      int idx = (h + i) % DEPTH;
      if (m_valid[idx] && m_key[idx] == k) begin
        exp_hit = 1'b1; exp_full = 1'b0; exp_id = idx; exp_lat = 2 + i;
        m_cnt[idx]++;
        break;
      end
      if (!m_valid[idx]) begin
        exp_new = 1'b1; exp_full = 1'b0; exp_id = idx; exp_lat = 2 + i;
        m_valid[idx] = 1'b1; m_key[idx] = k; m_cnt[idx] = 1;
        m_occ++;
        break;
      end
    end
    if (exp_full) m_drop++;
    exp_on = 1'b1;
  endfunction

  // Per-cycle comparison of the result bus against the model
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.result_valid) begin
        chk("result_expected", exp_on, 1);
        chk("result_hit", bus.result_hit, exp_hit);
        chk("result_new", bus.result_new, exp_new);
        chk("result_full", bus.result_full, exp_full);
        chk("result_id", bus.result_id, exp_id);
        chk("result_one_hot", bus.result_hit + bus.result_new + bus.result_full, 1);
        chk("occupancy", occupancy, m_occ);
        chk("drop_cnt", drop_cnt, m_drop);
      end else begin
        chk("result_idle_zero", {bus.result_hit, bus.result_new, bus.result_full, bus.result_id}, 0);
      end
    end
  end

  task automatic do_lookup(input logic [KW-1:0] k, input int hold, input bit clr, input bit exp_kr,
                           output bit o_hit, output bit o_new, output bit o_full, output int o_id);
    int lat;
    int waitc;
    @(negedge clk);
    bus.key       = k;
    bus.key_valid = 1'b1;
    waitc = 0;
    while (!bus.key_ready && waitc < 100) begin
      @(negedge clk);
      waitc++;
    end
    chk("key_ready_wait", bus.key_ready, 1);
    model_lookup(k);
    @(posedge clk);
    @(negedge clk);
    bus.key_valid = 1'b0;
    lat = 1;
    if (clr) clear_req = 1'b1;
    while (!bus.result_valid && lat < 40) begin
      @(negedge clk);
      clear_req = 1'b0;
      lat++;
    end
    chk("result_latency", lat, exp_lat);
    if (clr) chk("clear_busy_pending", clear_busy, 1);
    o_hit  = bus.result_hit;
    o_new  = bus.result_new;
    o_full = bus.result_full;
    o_id   = bus.result_id;
    for (int c = 0; c < hold; c++) begin
      chk("bp_key_ready", bus.key_ready, 0);
      chk("bp_valid_held", bus.result_valid, 1);
      chk("bp_id_stable", bus.result_id, o_id);
      @(negedge clk);
    end
    bus.result_ready = 1'b1;
    @(posedge clk);
    exp_on = 1'b0;
    @(negedge clk);
    bus.result_ready = 1'b0;
    chk("result_released", bus.result_valid, 0);
    chk("key_ready_after", bus.key_ready, exp_kr);
    $display("lookup key=%h hit=%0d new=%0d full=%0d id=%0d lat=%0d", k, o_hit, o_new, o_full, o_id, lat);
  endtask

  task automatic stat_read(input int a, output logic [CW-1:0] d);
    @(negedge clk);
    stat_re   = 1'b1;
    stat_addr = IW'(a);
    @(negedge clk);
    stat_re = 1'b0;
    d = stat_rdata;
    chk("stat_rvalid_pulse", stat_rvalid, 1);
`ifdef FLOW_STATS_EN
    chk("stat_rdata", stat_rdata, m_cnt[a]);
`else
    chk("stat_rdata", stat_rdata, 0);
`endif
    @(negedge clk);
    chk("stat_rvalid_drop", stat_rvalid, 0);
    $display("stat read addr=%0d data=%0d", a, d);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bit            h, n, f;
    int            id, cnt;
    logic [CW-1:0] sd;
    rst = 1'b1;
    bus.key_valid = 1'b0;
    bus.key = '0;
    bus.result_ready = 1'b0;
    clear_req = 1'b0;
    stat_re = 1'b0;
    stat_addr = '0;
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_result_valid", bus.result_valid, 0);
    chk("rst_key_ready", bus.key_ready, 1);
    chk("rst_occupancy", occupancy, 0);
    chk("rst_drop", drop_cnt, 0);
    chk("rst_clear_busy", clear_busy, 0);
    chk("rst_stat_rvalid", stat_rvalid, 0);
    chk("rst_stat_rdata", stat_rdata, 0);
    rst = 1'b0;

    // Insert A (h=3), then hit it
    do_lookup(16'h0003, 0, 1'b0, 1'b1, h, n, f, id);
    chk("A_new", n, 1);
    chk("A_id", id, 3);
    chk("A_occupancy", occupancy, 1);
    do_lookup(16'h0003, 0, 1'b0, 1'b1, h, n, f, id);
    chk("A_hit", h, 1);
    chk("A_hit_id", id, 3);
    stat_read(3, sd);
`ifdef FLOW_STATS_EN
    chk("A_count_literal", sd, 2);
`endif

    // B, C, D collide on h=3; B held under backpressure
    do_lookup(16'h0018, 5, 1'b0, 1'b1, h, n, f, id);
    chk("B_id", id, 4);
    do_lookup(16'h00C0, 0, 1'b0, 1'b1, h, n, f, id);
    chk("C_id", id, 5);
    do_lookup(16'h0600, 0, 1'b0, 1'b1, h, n, f, id);
    chk("D_id", id, 6);
    chk("BCD_occupancy", occupancy, 4);
    do_lookup(16'h0600, 0, 1'b0, 1'b1, h, n, f, id);
    chk("D_hit", h, 1);
    chk("D_hit_id", id, 6);
    chk("D_hit_lat_model", exp_lat, 5);

    // h=7 keys wrap through 7,0,1,2; the fifth is dropped
    for (int j = 0; j < 4; j++) begin
      do_lookup(k7[j], 0, 1'b0, 1'b1, h, n, f, id);
      chk("wrap_new", n, 1);
      chk("wrap_id", id, id7[j]);
    end
    do_lookup(k7[4], 0, 1'b0, 1'b1, h, n, f, id);
    chk("E5_full", f, 1);
    chk("E5_id", id, 0);
    chk("E5_drop", drop_cnt, 1);
    chk("E5_occupancy", occupancy, 8);

    // Clear requested mid-probe: lookup completes, then the sweep
    do_lookup(k7[4], 0, 1'b1, 1'b0, h, n, f, id);
    chk("clr_lookup_full", f, 1);
    cnt = 0;
    while (clear_busy && cnt < 40) begin
      cnt++;
      @(negedge clk);
    end
    $display("clear busy cycles=%0d", cnt);
    chk("clear_busy_len_ok", (cnt >= DEPTH) && (cnt <= DEPTH + 2), 1);
    for (int d = 0; d < DEPTH; d++) begin
      m_valid[d] = 1'b0;
      m_cnt[d]   = 0;
    end
    m_occ = 0;
    chk("clr_occupancy", occupancy, 0);
    chk("clr_drop_kept", drop_cnt, 2);
    chk("clr_key_ready", bus.key_ready, 1);
    do_lookup(16'h0003, 0, 1'b0, 1'b1, h, n, f, id);
    chk("A_after_clear_new", n, 1);
    chk("A_after_clear_id", id, 3);
    stat_read(4, sd);
    stat_read(3, sd);

    // Reset in the middle of a clear sweep
    @(negedge clk);
    clear_req = 1'b1;
    @(negedge clk);
    clear_req = 1'b0;
    chk("clr2_busy", clear_busy, 1);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midclr_rst_busy", clear_busy, 0);
    chk("midclr_rst_occ", occupancy, 0);
    chk("midclr_rst_drop", drop_cnt, 0);
    chk("midclr_rst_rvalid", bus.result_valid, 0);
    chk("midclr_rst_stat_rvalid", stat_rvalid, 0);
    chk("midclr_rst_stat_rdata", stat_rdata, 0);
    chk("midclr_rst_key_ready", bus.key_ready, 1);
    model_reset();
    rst = 1'b0;
    do_lookup(16'h0003, 0, 1'b0, 1'b1, h, n, f, id);
    chk("post_rst_new", n, 1);
    chk("post_rst_occ", occupancy, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
